fp32_div_result_queue: RTL and testbench

//  Registered downstream stage for fp32_div_comb: captures each divide result (y + 5 IEEE exception

---
 rtl/fp32_pkg.sv | 22 ++
 rtl/fp32_div_result_queue_if.sv | 33 +++
 rtl/fp32_nan_canon.sv | 21 ++
 rtl/fp32_div_result_queue.sv | 98 +++++++++
 tb/tb_fp32_div_result_queue.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/fp32_pkg.sv
// Purpose: shared fp32 definitions (exception flag bit positions, flag type, canonical NaN).
// Latency: n/a (types, constants and a pure helper function only).
// Backpressure: n/a.
package fp32_pkg;

  // Bit positions inside a 5-bit IEEE exception flag vector
  localparam int FLAG_NV = 4;  // invalid
  localparam int FLAG_DZ = 3;  // divide by zero
  localparam int FLAG_OF = 2;  // overflow
  localparam int FLAG_UF = 1;  // underflow
  localparam int FLAG_NX = 0;  // inexact

  typedef logic [4:0] fp_flags_t;

  localparam logic [31:0] CANON_QNAN = 32'h7FC0_0000;

  // Exponent all ones with a non-zero mantissa; infinities are excluded
  function automatic logic is_nan32(input logic [31:0] y);
    return (y[30:23] == 8'hFF) && (y[22:0] != 23'd0);
  endfunction

endpackage

// File: rtl/fp32_div_result_queue_if.sv
// Purpose: producer-side and consumer-side handshakes of the divide result queue.
// Latency: n/a (wiring only).
// Backpressure: in_ready/out_ready carry the valid/ready stalls in each direction.
interface fp32_div_result_queue_if #(
  parameter int TAG_W = 5
);
  import fp32_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_y;
  fp_flags_t        in_flags;
  logic [TAG_W-1:0] in_tag;

  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_y;
  fp_flags_t        out_flags;
  logic [TAG_W-1:0] out_tag;

  // Environment side: produces divider results and consumes the queue head
  modport master (
    output in_valid, in_y, in_flags, in_tag, out_ready,
    input  in_ready, out_valid, out_y, out_flags, out_tag
  );

  // Queue side
  modport slave (
    input  in_valid, in_y, in_flags, in_tag, out_ready,
    output in_ready, out_valid, out_y, out_flags, out_tag
  );

endinterface

// File: rtl/fp32_nan_canon.sv
// Purpose: optionally replace any NaN with the single canonical quiet NaN.
// Latency: combinational.
// Backpressure: none.
module fp32_nan_canon
  import fp32_pkg::*;
#(
  parameter bit CANON_NAN = 1'b1
) (
  input  logic [31:0] y_in,
  output logic [31:0] y_out
);

  // Infinities and ordinary numbers pass untouched; NaN sign/payload dropped when enabled
  always_comb begin
    y_out = y_in;
    if (CANON_NAN && is_nan32(y_in)) begin
      y_out = CANON_QNAN;
    end
  end

endmodule

// File: rtl/fp32_div_result_queue.sv
// Purpose: registered FIFO for divide results with sticky exception accrual at retirement.
// Latency: a result pushed in cycle N is presented at out_* in cycle N+1 at the earliest.
// Backpressure: in_ready drops when DEPTH entries are held; out_* hold while out_ready is low.
module fp32_div_result_queue
  import fp32_pkg::*;
#(
  parameter int DEPTH     = 4,
  parameter int TAG_W     = 5,
  parameter bit CANON_NAN = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  fp32_div_result_queue_if.slave   q,
  output fp_flags_t                fflags,
  input  logic                     csr_wr,
  input  fp_flags_t                csr_wdata,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int             PTR_W    = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

  typedef struct packed {
    logic [31:0]      y;
    fp_flags_t        flags;
    logic [TAG_W-1:0] tag;
  } entry_t;

  entry_t           mem_q [DEPTH];
  entry_t           head;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  fp_flags_t        fflags_q, fflags_d;
  logic [31:0]      y_canon;
  logic             push;
  logic             pop;

  // NaN canonicalisation happens before storage so the head is already clean
  fp32_nan_canon #(
    .CANON_NAN (CANON_NAN)
  ) u_nan_canon (
    .y_in  (q.in_y),
    .y_out (y_canon)
  );

  // Ready depends only on occupancy, so a full queue never accepts even if a pop is in flight
  assign q.in_ready  = (count_q != FULL_CNT);
  assign q.out_valid = (count_q != '0);
  assign push        = q.in_valid && q.in_ready;
  assign pop         = q.out_valid && q.out_ready;

  // Head is read straight from storage; zero while empty so reset clears the outputs
  assign head        = mem_q[rd_ptr_q];
  assign q.out_y     = q.out_valid ? head.y     : 32'd0;
  assign q.out_flags = q.out_valid ? head.flags : 5'd0;
  assign q.out_tag   = q.out_valid ? head.tag   : '0;

  assign fflags = fflags_q;
  assign count  = count_q;

  // Next-state for pointers, occupancy and the sticky flags
  always_comb begin
    rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    count_d  = count_q;
    if (push && !pop) begin
      count_d = count_q + (PTR_W + 1)'(1);
    end else if (pop && !push) begin
      count_d = count_q - (PTR_W + 1)'(1);
    end
    // A CSR write and a retirement in the same cycle merge; retiring flags are never lost
    fflags_d = (csr_wr ? csr_wdata : fflags_q) | (pop ? q.out_flags : 5'd0);
  end

  // Entry storage; deliberately not reset, contents are qualified by count
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= '{y: y_canon, flags: q.in_flags, tag: q.in_tag};
    end
  end

  // Control state with asynchronous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      fflags_q <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      fflags_q <= fflags_d;
    end
  end

endmodule

// File: tb/tb_fp32_div_result_queue.sv
// Purpose: scoreboard bench for fp32_div_result_queue using hand-computed divide results.
// Latency: checks first visibility one cycle after push and strict push-order delivery.
// Backpressure: exercises full-queue stalls, held valids and random consumer stalls.
module tb_fp32_div_result_queue;
  import fp32_pkg::*;

  localparam int DEPTH = 4;
  localparam int TAG_W = 5;

  typedef struct {
    logic [31:0] y;
    logic [4:0]  f;
    logic [4:0]  tag;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic       csr_wr;
  logic [4:0] csr_wdata;
  logic [4:0] fflags;
  logic [2:0] count;

  fp32_div_result_queue_if #(.TAG_W(TAG_W)) ifc ();

  fp32_div_result_queue #(
    .DEPTH     (DEPTH),
    .TAG_W     (TAG_W),
    .CANON_NAN (1'b1)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .q         (ifc),
    .fflags    (fflags),
    .csr_wr    (csr_wr),
    .csr_wdata (csr_wdata),
    .count     (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t sb[$];
  exp_t drv_exp;
  logic [4:0] exp_ff = 5'd0;
  bit   mon_en  = 1'b0;
  bit   acc_flag = 1'b0;

  // Hand-computed divider results: input y, flags, and the y expected at the output
  logic [31:0] vy   [9] = '{32'h3F00_0000, 32'h7FE0_0001, 32'h7F80_0000, 32'hFFC1_2345,
                            32'h3EAA_AAAB, 32'h0000_0000, 32'h7F80_0000, 32'h7F80_0001,
                            32'hFF80_0000};
  logic [4:0]  vf   [9] = '{5'b00000, 5'b10000, 5'b01000, 5'b10000,
                            5'b00001, 5'b00011, 5'b00101, 5'b10000, 5'b01000};
  logic [31:0] vexp [9] = '{32'h3F00_0000, 32'h7FC0_0000, 32'h7F80_0000, 32'h7FC0_0000,
                            32'h3EAA_AAAB, 32'h0000_0000, 32'h7F80_0000, 32'h7FC0_0000,
                            32'hFF80_0000};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: checks occupancy/handshake/flags every cycle and pops the scoreboard on retirement
  always @(negedge clk) begin
    if (mon_en && rst_n) begin
      int   mc;
      bit   pop_m;
      bit   acc;
      exp_t e;
      mc = sb.size();
      chk("count", 32'(count), 32'(mc));
      chk("in_ready", 32'(ifc.in_ready), 32'(mc != DEPTH));
      chk("out_valid", 32'(ifc.out_valid), 32'(mc != 0));
      chk("fflags", 32'(fflags), 32'(exp_ff));
      pop_m = (mc != 0) && ifc.out_ready;
      e = '{32'd0, 5'd0, 5'd0};
      if (pop_m) begin
        e = sb[0];
        chk("out_y", ifc.out_y, e.y);
        chk("out_flags", 32'(ifc.out_flags), 32'(e.f));
        chk("out_tag", 32'(ifc.out_tag), 32'(e.tag));
        void'(sb.pop_front());
      end
      exp_ff = (csr_wr ? csr_wdata : exp_ff) | (pop_m ? e.f : 5'd0);
      acc = ifc.in_valid && (mc != DEPTH);
      if (acc) sb.push_back(drv_exp);
      acc_flag = acc;
    end
  end

  task automatic drive(input logic [31:0] y, input logic [4:0] f, input logic [4:0] tag,
                       input logic [31:0] ey);
    ifc.in_valid = 1'b1;
    ifc.in_y     = y;
    ifc.in_flags = f;
    ifc.in_tag   = tag;
    drv_exp      = '{ey, f, tag};
  endtask

  // Present one result and hold it until accepted (bounded)
  task automatic push(input logic [31:0] y, input logic [4:0] f, input logic [4:0] tag,
                      input logic [31:0] ey);
    bit ok;
    ok = 1'b0;
    drive(y, f, tag, ey);
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #1;
      if (acc_flag) begin
        ok = 1'b1;
        break;
      end
    end
    ifc.in_valid = 1'b0;
    chk("push_accepted", 32'(ok), 32'd1);
  endtask

  task automatic wait_empty(input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (sb.size() == 0) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    chk(name, 32'(ok), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n         = 1'b0;
    ifc.in_valid  = 1'b0;
    ifc.in_y      = 32'd0;
    ifc.in_flags  = 5'd0;
    ifc.in_tag    = 5'd0;
    ifc.out_ready = 1'b0;
    csr_wr        = 1'b0;
    csr_wdata     = 5'd0;
    drv_exp       = '{32'd0, 5'd0, 5'd0};
    #12;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_out_valid", 32'(ifc.out_valid), 32'd0);
    chk("rst_in_ready", 32'(ifc.in_ready), 32'd1);
    chk("rst_fflags", 32'(fflags), 32'd0);
    chk("rst_out_y", ifc.out_y, 32'd0);
    chk("rst_out_tag", 32'(ifc.out_tag), 32'd0);
    @(posedge clk); #1;
    rst_n  = 1'b1;
    mon_en = 1'b1;

    // 1.0 / 2.0 with a ready consumer: visible next cycle, no flags accrued
    ifc.out_ready = 1'b1;
    push(32'h3F00_0000, 5'b00000, 5'd3, 32'h3F00_0000);
    chk("t1_visible_next", 32'(ifc.out_valid), 32'd1);
    wait_empty("t1_drain");
    @(posedge clk); #1;
    chk("t1_fflags", 32'(fflags), 32'd0);

    // Fill to DEPTH with consumer stalled, hold a fifth valid, then drain in order
    ifc.out_ready = 1'b0;
    push(32'h3F80_0000, 5'b00000, 5'd10, 32'h3F80_0000);
    push(32'h4000_0000, 5'b00000, 5'd11, 32'h4000_0000);
    push(32'h4040_0000, 5'b00000, 5'd12, 32'h4040_0000);
    push(32'h4080_0000, 5'b00000, 5'd13, 32'h4080_0000);
    drive(32'h40A0_0000, 5'b00000, 5'd14, 32'h40A0_0000);
    repeat (3) @(posedge clk);
    #1;
    chk("t2_full_count", 32'(count), 32'(DEPTH));
    chk("t2_full_in_ready", 32'(ifc.in_ready), 32'd0);
    ifc.in_valid  = 1'b0;
    ifc.out_ready = 1'b1;
    wait_empty("t2_drain");
    @(posedge clk); #1;
    chk("t2_empty_count", 32'(count), 32'd0);

    // NaN result canonicalised; invalid flag accrues only after retirement
    ifc.out_ready = 1'b0;
    push(32'h7FE0_0001, 5'b10000, 5'd7, 32'h7FC0_0000);
    chk("t3_fflags_before_pop", 32'(fflags), 32'd0);
    chk("t3_out_y_canon", ifc.out_y, 32'h7FC0_0000);
    ifc.out_ready = 1'b1;
    wait_empty("t3_drain");
    @(posedge clk); #1;
    chk("t3_fflags", 32'(fflags), 32'b10000);

    // CSR write coinciding with retirement of a divide-by-zero result
    ifc.out_ready = 1'b0;
    push(32'h7F80_0000, 5'b01000, 5'd9, 32'h7F80_0000);
    csr_wr        = 1'b1;
    csr_wdata     = 5'b00001;
    ifc.out_ready = 1'b1;
    @(posedge clk); #1;
    csr_wr        = 1'b0;
    csr_wdata     = 5'd0;
    chk("t4_fflags_merge", 32'(fflags), 32'b01001);

    // Asynchronous reset with two entries queued, then normal operation resumes
    ifc.out_ready = 1'b0;
    push(32'h3EAA_AAAB, 5'b00001, 5'd1, 32'h3EAA_AAAB);
    push(32'h4000_0000, 5'b00000, 5'd2, 32'h4000_0000);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_rst_out_valid", 32'(ifc.out_valid), 32'd0);
    chk("t5_rst_count", 32'(count), 32'd0);
    chk("t5_rst_fflags", 32'(fflags), 32'd0);
    sb.delete();
    exp_ff = 5'd0;
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    push(32'hFFC1_2345, 5'b10000, 5'd21, 32'h7FC0_0000);
    chk("t5_post_rst_y", ifc.out_y, 32'h7FC0_0000);
    chk("t5_post_rst_tag", 32'(ifc.out_tag), 32'd21);
    ifc.out_ready = 1'b1;
    wait_empty("t5_drain");

    // Random producer/consumer handshakes over the directed result table, with CSR writes
    for (int k = 0; k < 3000; k++) begin
      int idx;
      @(posedge clk); #1;
      idx = $urandom_range(0, 8);
      drive(vy[idx], vf[idx], 5'(k), vexp[idx]);
      ifc.in_valid  = ($urandom_range(0, 2) != 0);
      ifc.out_ready = ($urandom_range(0, 2) != 0);
      csr_wr        = ($urandom_range(0, 31) == 0);
      csr_wdata     = 5'($urandom_range(0, 31));
    end
    @(posedge clk); #1;
    ifc.in_valid  = 1'b0;
    csr_wr        = 1'b0;
    ifc.out_ready = 1'b1;
    wait_empty("t6_drain");
    repeat (2) @(posedge clk);
    #1;
    chk("t6_final_count", 32'(count), 32'd0);

    mon_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
